// File: rtl/sort_dp_bank_mem.sv
// Banked 1R1W word store for the sort datapath, with a power-on init
// engine and a fixed-latency read path that flags its output valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   init_busy  high while every word is being cleared to INIT_VAL
//   wr_vld     write request; wr_addr / data_in give address and data
//   rd_vld     read request; rd_addr gives the address
//   data_out   read data, held until the next rd_dvld
//   rd_dvld    one-cycle pulse, RD_LAT cycles after an accepted read
//   err_drop   sticky: a request arrived while init_busy was high
//
// Build option: define SORT_DP_BANK_BYPASS_EN to forward data_in to a
// same-cycle read of the address being written; otherwise such a read
// returns the previously stored word.
module sort_dp_bank_mem #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 10,
  parameter int NUM_SRAM   = 2,
  parameter int RD_LAT     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_dvld,
  output logic                  err_drop
);

  localparam int SB  = $clog2(NUM_SRAM);
  localparam int SBW = (SB > 0) ? SB : 1;
  localparam int LW  = ADDR_WIDTH - SB;
  localparam int D   = 1 << LW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_ic;
  logic            r_init_busy;
  logic            r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_ic        <= '0;
      r_init_busy <= 1'b1;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_ic <= r_ic + 1'b1;
          if (&r_ic) begin
            r_state     <= S_RUN;
            r_init_busy <= 1'b0;
          end
        end
        S_RUN: r_init_busy <= 1'b0;
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign init_busy = r_init_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (r_init_busy && (wr_vld || rd_vld)) r_err <= 1'b1;
  end

  assign err_drop = r_err;

  logic                  w_rd_acc;
  logic [SBW-1:0]        w_wr_sb;
  logic [SBW-1:0]        w_rd_sb;
  logic [LW-1:0]         w_rd_la;
  logic [LW-1:0]         w_wa;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [NUM_SRAM-1:0]   w_we;
  logic [NUM_SRAM-1:0]   w_re;
  logic [DATA_WIDTH-1:0] w_q [NUM_SRAM];

  assign w_rd_acc = rd_vld & ~r_init_busy;
  // Shifting out the local bits yields 0 when there is only one bank.
  assign w_wr_sb  = SBW'(wr_addr >> LW);
  assign w_rd_sb  = SBW'(rd_addr >> LW);
  assign w_rd_la  = rd_addr[LW-1:0];
  // The init engine owns the write port of every bank while busy.
  assign w_wa = r_init_busy ? r_ic : wr_addr[LW-1:0];
  assign w_wd = r_init_busy ? INIT_VAL : data_in;

  always_comb begin
    w_we = '0;
    w_re = '0;
    for (int g = 0; g < NUM_SRAM; g++) begin
      w_we[g] = r_init_busy | (wr_vld & (w_wr_sb == SBW'(g)));
      w_re[g] = w_rd_acc & (w_rd_sb == SBW'(g));
    end
  end

  for (genvar g = 0; g < NUM_SRAM; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [D];
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      if (w_we[g]) r_mem[w_wa] <= w_wd;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_q <= '0;
      else if (w_re[g]) r_q <= r_mem[w_rd_la];
    end

    assign w_q[g] = r_q;
  end

  logic                  r_v1;
  logic [SBW-1:0]        r_rsb;
  logic [DATA_WIDTH-1:0] w_d1;

  // Mux select is the bank captured with the read, so a later address
  // change cannot disturb the held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_rsb <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) r_rsb <= w_rd_sb;
    end
  end

`ifdef SORT_DP_BANK_BYPASS_EN
  logic                  r_byp;
  logic [DATA_WIDTH-1:0] r_bdat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byp  <= 1'b0;
      r_bdat <= '0;
    end else if (w_rd_acc) begin
      r_byp  <= wr_vld & (wr_addr == rd_addr);
      r_bdat <= data_in;
    end
  end

  assign w_d1 = r_byp ? r_bdat : w_q[r_rsb];
`else
  assign w_d1 = w_q[r_rsb];
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dout <= '0;
        r_dv2  <= 1'b0;
      end else begin
        r_dv2 <= r_v1;
        if (r_v1) r_dout <= w_d1;
      end
    end

    assign data_out = r_dout;
    assign rd_dvld  = r_dv2;
  end else begin : g_lat1
    assign data_out = w_d1;
    assign rd_dvld  = r_v1;
  end

endmodule

// File: doc/sort_dp_bank_mem.md
# sort_dp_bank_mem

Parametrised banked 1R1W memory for the sort datapath; it holds one bank of the sort value/count store. The address space splits across `NUM_SRAM` physical sub-banks, selected by the address MSBs. After reset, a built-in init engine clears every location to `INIT_VAL`. Reads have a fixed 1- or 2-cycle latency, with an explicit data-valid output and optional read-during-write forwarding.

## Interface
- `ADDR_WIDTH`, 13, total word address width.
- `DATA_WIDTH`, 10, word width.
- `NUM_SRAM`, 2, physical sub-banks; power of two, 1..8.
- `RD_LAT`, 1, read latency in cycles; 1 or 2. With 2, an output register is added.
- `INIT_VAL`, 0, value written to every word by the init engine.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `init_busy`  out  1  high while the init engine runs; no accesses are accepted.
- `wr_vld`  in  1  write request.
- `wr_addr`  in  `ADDR_WIDTH`  write address.
- `data_in`  in  `DATA_WIDTH`  write data.
- `rd_vld`  in  1  read request.
- `rd_addr`  in  `ADDR_WIDTH`  read address.
- `data_out`  out  `DATA_WIDTH`  read data; held between reads.
- `rd_dvld`  out  1  one-cycle pulse marking `data_out` valid.
- `err_drop`  out  1  sticky flag: a request arrived while `init_busy` was high.

## Operation
- Sub-bank geometry:
  - `SB = log2(NUM_SRAM)`.
  - Sub-bank index = `addr[ADDR_WIDTH-1 -: SB]` (always 0 when `NUM_SRAM` = 1).
  - Local address = `addr[ADDR_WIDTH-SB-1:0]`.
  - Sub-bank depth `D = 2^ADDR_WIDTH / NUM_SRAM`.
- Sub-bank enables: each sub-bank has its own CE/WE. CE is asserted only when a read or write targets that sub-bank. A read and a write may hit different sub-banks, or the same one (each sub-bank is 1R1W); both are always serviced in the same cycle.
- FSM, two states:
  - INIT: entered from reset. Local counter `ic` runs 0..D-1 and writes `INIT_VAL` to `ic` in all sub-banks in parallel. At `ic` = D-1 → RUN. `init_busy` = 1.
  - RUN: normal access. `init_busy` = 0. No exit except reset.
- Request handling:
  - Requests with `init_busy` = 1 are discarded: no write, no `rd_dvld`, and `err_drop` is set (stays 1 until reset).
  - A read accepted in cycle t registers the sub-bank index. The output mux uses this registered index, never the live address.
- Output hold: `data_out` keeps the last read result until the next `rd_dvld`.
- Same-address read and write in the same cycle: see Configuration.

## Timing
- Reset values: `init_busy` = 1, `rd_dvld` = 0, `data_out` = 0, `err_drop` = 0, FSM = INIT, `ic` = 0.
- Init duration: exactly D cycles after `rst` deasserts. `init_busy` falls on the edge following the write of `ic` = D-1, and a request is accepted in that same cycle.
- Read latency: a read accepted at edge t gives `rd_dvld` = 1 and valid `data_out` at t+`RD_LAT`.
- Throughput: one read per cycle, back-to-back, with no bubbles.
- Write visibility: a write at edge t is visible to a read accepted at t+1 or later.
- Reset mid-init or mid-read:
  - The FSM returns to INIT and `ic` to 0.
  - In-flight reads are discarded: `rd_dvld` is not pulsed.
  - Memory contents are undefined until the new init completes.
- Out-of-range addresses do not exist, because the full `ADDR_WIDTH` space is backed.

## Configuration
- `SORT_DP_BANK_BYPASS_EN`:
  - Defined: a read and write to the same address in the same cycle returns the new `data_in` at t+`RD_LAT`. The comparator and data mux sit before the output register.
  - Undefined: the same case returns the old stored contents (read-before-write); no compare logic is built.
  - Either way, the write always lands.

## Test plan
- Init: deassert `rst` with `ADDR_WIDTH` = 7, `NUM_SRAM` = 2 → `init_busy` is high for exactly 64 cycles. Reads of addresses 0, 63, 64 and 127 then return `INIT_VAL` (0) with `rd_dvld` at t+1.
- Cross-bank: write 0x155 @ 5 and 0x2AA @ 69, then read 5, 69 and 5 back-to-back → `data_out` = 0x155, 0x2AA, 0x155 on consecutive cycles. `rd_dvld` stays high for 3 cycles, then `data_out` holds 0x155.
- Collision: with 0x011 stored @ 10, drive a write of 0x3FF @ 10 and a read @ 10 in the same cycle → returns 0x3FF with `SORT_DP_BANK_BYPASS_EN`, 0x011 without. A read @ 10 on the next cycle returns 0x3FF in both builds.
- `RD_LAT` = 2, `NUM_SRAM` = 8: read 8 addresses in distinct sub-banks back-to-back → each `rd_dvld` and data appears exactly 2 cycles after its request, in order.
- Drop: assert `wr_vld` @ 3 with 0x0AA during init → `err_drop` = 1 and stays 1. After init, a read @ 3 returns 0.
- Reset mid-operation: pull `rst` low one cycle after a read is issued → no `rd_dvld` appears. `init_busy` re-asserts and a full D-cycle init reruns.
